uart_alu_ctrl: RTL

//   Command sequencer between the UART receiver, the ALU and the UART transmitter.

---
 rtl/uart_alu_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// Command sequencer: gathers operand A, operand B and opcode from the UART receiver,
// runs the ALU for one cycle and hands the result to the UART transmitter.
//
// state   | meaning
// GET_A   | idle, waiting for operand A (no timeout)
// GET_B   | waiting for operand B, inter-byte timer running
// GET_OP  | waiting for opcode, inter-byte timer running
// EXEC    | capture ALU result into o_tx_data
// SEND    | wait for transmitter idle, then pulse o_tx_start
// WAIT_TX | wait for transmitter done
module uart_alu_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int NB_STATE    = 3,
  parameter int NB_TIMEOUT  = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  typedef enum logic [NB_STATE-1:0] {
    GET_A   = NB_STATE'(0),
    GET_B   = NB_STATE'(1),
    GET_OP  = NB_STATE'(2),
    EXEC    = NB_STATE'(3),
    SEND    = NB_STATE'(4),
    WAIT_TX = NB_STATE'(5)
  } state_t;

  // Timer counts down from the load value; reaching zero is the terminal count.
  localparam logic [NB_TIMEOUT-1:0] CNT_LOAD = NB_TIMEOUT'(TIMEOUT_CYC - 1);

  state_t                state, state_next;
  logic [NB_TIMEOUT-1:0] cnt, cnt_next;
  logic [NB_DATA-1:0]    alu_a_next, alu_b_next, tx_data_next;
  logic [NB_OP-1:0]      alu_op_next;
  logic                  tx_start_next, timeout_next, overrun_next;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= GET_A;
      cnt        <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      o_alu_a    <= alu_a_next;
      o_alu_b    <= alu_b_next;
      o_alu_op   <= alu_op_next;
      o_tx_data  <= tx_data_next;
      o_tx_start <= tx_start_next;
      o_timeout  <= timeout_next;
      o_overrun  <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = '0;
    alu_a_next    = o_alu_a;
    alu_b_next    = o_alu_b;
    alu_op_next   = o_alu_op;
    tx_data_next  = o_tx_data;
    tx_start_next = 1'b0;
    timeout_next  = 1'b0;
    overrun_next  = 1'b0;
    case (state)
      GET_A: begin
        if (i_rx_done) begin
          alu_a_next = i_rx_data;
          cnt_next   = CNT_LOAD;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (i_rx_done) begin
          alu_b_next = i_rx_data;
          cnt_next   = CNT_LOAD;
          state_next = GET_OP;
        end else if (cnt == '0) begin
          timeout_next = 1'b1;
          state_next   = GET_A;
        end else begin
          cnt_next = cnt - NB_TIMEOUT'(1);
        end
      end
      GET_OP: begin
        if (i_rx_done) begin
          alu_op_next = i_rx_data[NB_OP-1:0];
          state_next  = EXEC;
        end else if (cnt == '0) begin
          timeout_next = 1'b1;
          state_next   = GET_A;
        end else begin
          cnt_next = cnt - NB_TIMEOUT'(1);
        end
      end
      EXEC: begin
        overrun_next = i_rx_done;
        tx_data_next = i_alu_result;
        state_next   = SEND;
      end
      SEND: begin
        overrun_next = i_rx_done;
        if (!i_tx_busy) begin
          tx_start_next = 1'b1;
          state_next    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        overrun_next = i_rx_done;
        if (i_tx_done) state_next = GET_A;
      end
      default: state_next = GET_A;
    endcase
  end

  assign o_busy = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

endmodule
